// File: rtl/lcd_pkg.sv
// Shared timing defaults, dot-phase encodings and sizing helper for the LCD timing path.
package lcd_pkg;

  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 320;
  localparam int unsigned H_FP_DEF     = 20;
  localparam int unsigned H_SYNC_DEF   = 30;
  localparam int unsigned H_BP_DEF     = 38;
  localparam int unsigned V_ACTIVE_DEF = 240;
  localparam int unsigned V_FP_DEF     = 4;
  localparam int unsigned V_SYNC_DEF   = 1;
  localparam int unsigned V_BP_DEF     = 18;

  localparam logic [1:0] PHASE_R = 2'd0;
  localparam logic [1:0] PHASE_G = 2'd1;
  localparam logic [1:0] PHASE_B = 2'd2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: steps through active, front porch, sync and back porch, and flags
// the active and sync windows on registered outputs.
module lcd_axis_cnt
  import lcd_pkg::*;
#(
  parameter int unsigned ACTIVE = 6,
  parameter int unsigned FP     = 1,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned BP     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  input  logic upd,
  output logic active,
  output logic sync_n,
  output logic wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  localparam int unsigned CW    = clog2(TOTAL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   nxt;

  assign wrap  = tick && (32'(cnt_q) == TOTAL - 1);
  assign cnt_d = wrap ? '0 : (tick ? cnt_q + 1'b1 : cnt_q);
  assign nxt   = 32'(cnt_d);

  // Flags refresh on upd (every dot) so the vertical flags are valid from the first dot
  // after reset, even though that axis only counts on line wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      active <= 1'b0;
      sync_n <= 1'b1;
    end else if (clr) begin
      cnt_q  <= '0;
      active <= 1'b0;
      sync_n <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (upd) begin
        active <= (nxt < ACTIVE);
        sync_n <= !((nxt >= ACTIVE + FP) && (nxt < ACTIVE + FP + SYNC));
      end
    end
  end

endmodule

// File: rtl/lcd_sync_gen.sv
// Serial-RGB LCD timing generator: dot clock divider, h/v sync, active flags, dot phase
// and linear frame-buffer read address.
module lcd_sync_gen
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  output logic              CLKIN,
  output logic              lcd_hsync,
  output logic              lcd_vsync,
  output logic              H_DONE,
  output logic              V_DONE,
  output logic [1:0]        dot_phase,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              line_start,
  output logic              frame_start
);

  localparam int unsigned H_DOTS = 3 * H_ACTIVE;
  localparam int unsigned DW     = clog2(CLK_DIV);

  logic [DW-1:0] div_cnt_q;
  logic [1:0]    ph_q;
  logic          dot_tick, h_wrap, v_wrap, clr;

  assign clr      = !enable;
  assign dot_tick = (32'(div_cnt_q) == CLK_DIV - 1);

  lcd_axis_cnt #(
    .ACTIVE(H_DOTS),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP)
  ) u_h_axis (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr   (clr),
    .tick  (dot_tick),
    .upd   (dot_tick),
    .active(H_DONE),
    .sync_n(lcd_hsync),
    .wrap  (h_wrap)
  );

  lcd_axis_cnt #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP)
  ) u_v_axis (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .clr   (clr),
    .tick  (h_wrap),
    .upd   (dot_tick),
    .active(V_DONE),
    .sync_n(lcd_vsync),
    .wrap  (v_wrap)
  );

  // ph_q follows hcnt mod 3 and updates on the same edge as H_DONE, so masking it with
  // H_DONE keeps dot_phase a pure function of flops.
  assign dot_phase = H_DONE ? ph_q : PHASE_R;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt_q   <= '0;
      ph_q        <= PHASE_R;
      CLKIN       <= 1'b0;
      ram_addr    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (clr) begin
      div_cnt_q   <= '0;
      ph_q        <= PHASE_R;
      CLKIN       <= 1'b0;
      ram_addr    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt_q   <= dot_tick ? '0 : div_cnt_q + 1'b1;
      CLKIN       <= (32'(div_cnt_q) >= CLK_DIV / 2);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      if (dot_tick) begin
        if (h_wrap) begin
          ph_q <= PHASE_R;
        end else begin
          case (ph_q)
            PHASE_R: ph_q <= PHASE_G;
            PHASE_G: ph_q <= PHASE_B;
            default: ph_q <= PHASE_R;
          endcase
        end
        if (v_wrap) begin
          ram_addr <= '0;
        end else if (dot_phase == PHASE_B && H_DONE && V_DONE) begin
          ram_addr <= ram_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Bench for lcd_sync_gen with small timing: outputs checked every cycle against a model
// that derives everything from the count of enabled clock edges since the last clear.
module tb_lcd_sync_gen;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned H_ACTIVE = 2;
  localparam int unsigned H_FP     = 1;
  localparam int unsigned H_SYNC   = 2;
  localparam int unsigned H_BP     = 1;
  localparam int unsigned V_ACTIVE = 2;
  localparam int unsigned V_FP     = 1;
  localparam int unsigned V_SYNC   = 1;
  localparam int unsigned V_BP     = 1;
  localparam int unsigned ADDR_W   = 4;

  localparam int unsigned H_DOTS    = 3 * H_ACTIVE;
  localparam int unsigned H_TOTAL   = H_DOTS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LINE_CYC  = H_TOTAL * CLK_DIV;
  localparam int unsigned FRAME_CYC = LINE_CYC * V_TOTAL;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              enable  = 1'b0;
  logic              CLKIN, lcd_hsync, lcd_vsync, H_DONE, V_DONE, line_start, frame_start;
  logic [1:0]        dot_phase;
  logic [ADDR_W-1:0] ram_addr;

  int total = 0;
  int bad   = 0;
  int unsigned k = 0;

  typedef struct {
    logic        clkin, hs, vs, hd, vd, ls, fs;
    logic [1:0]  ph;
    int unsigned addr;
  } exp_t;

  lcd_sync_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .ADDR_W  (ADDR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .CLKIN      (CLKIN),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .H_DONE     (H_DONE),
    .V_DONE     (V_DONE),
    .dot_phase  (dot_phase),
    .ram_addr   (ram_addr),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 sys_clk = ~sys_clk;

  // Enabled edges since the last reset or enable-low edge.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst || !enable) k <= 0;
    else k <= k + 1;
  end

  function automatic exp_t model(input int unsigned kk);
    exp_t e;
    int unsigned t, h, v;
    t = kk / CLK_DIV;
    h = t % H_TOTAL;
    v = (t / H_TOTAL) % V_TOTAL;
    e.clkin = (kk != 0) && (((kk - 1) % CLK_DIV) >= CLK_DIV / 2);
    if (t == 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.hd = 1'b0; e.vd = 1'b0;
      e.ph = 2'd0; e.addr = 0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      e.hd   = (h < H_DOTS);
      e.vd   = (v < V_ACTIVE);
      e.hs   = !(h >= H_DOTS + H_FP && h < H_DOTS + H_FP + H_SYNC);
      e.vs   = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      e.ph   = e.hd ? 2'(h % 3) : 2'd0;
      e.addr = !e.vd ? H_ACTIVE * V_ACTIVE : v * H_ACTIVE + (e.hd ? h / 3 : H_ACTIVE);
      e.ls   = ((kk % CLK_DIV) == 0) && (h == 0);
      e.fs   = e.ls && (v == 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, expv, k);
    end
  endtask

  task automatic check_all(input string tag);
    exp_t e;
    e = model(k);
    chk({tag, ".CLKIN"}, 32'(CLKIN), 32'(e.clkin));
    chk({tag, ".hsync"}, 32'(lcd_hsync), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(lcd_vsync), 32'(e.vs));
    chk({tag, ".H_DONE"}, 32'(H_DONE), 32'(e.hd));
    chk({tag, ".V_DONE"}, 32'(V_DONE), 32'(e.vd));
    chk({tag, ".phase"}, 32'(dot_phase), 32'(e.ph));
    chk({tag, ".addr"}, 32'(ram_addr), e.addr);
    chk({tag, ".line_start"}, 32'(line_start), 32'(e.ls));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(e.fs));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, last_ls, last_fs, hd_cnt, r;
    bit hit;
    exp_t e;

    // Reset held: everything at reset values.
    sys_rst = 1'b1;
    enable  = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      check_all("reset");
    end
    sys_rst = 1'b0;

    // Two clean frames: per-cycle model plus line/frame period and active length.
    cyc = 0; last_ls = -1; last_fs = -1; hd_cnt = 0;
    repeat (2 * FRAME_CYC + 10) begin
      @(negedge sys_clk);
      cyc++;
      check_all("run");
      if (line_start) begin
        if (last_ls >= 0) begin
          chk("ls_period", 32'(cyc - last_ls), LINE_CYC);
          chk("hdone_len", 32'(hd_cnt), H_DOTS * CLK_DIV);
        end
        last_ls = cyc;
        hd_cnt  = 0;
      end
      if (H_DONE) hd_cnt++;
      if (frame_start) begin
        chk("fs_addr", 32'(ram_addr), 0);
        if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), FRAME_CYC);
        last_fs = cyc;
      end
    end

    // Async reset mid-active: line 1, dot 3.
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME_CYC && !hit; i++) begin
      @(negedge sys_clk);
      check_all("seek_mid");
      hit = ((k / CLK_DIV) % (H_TOTAL * V_TOTAL)) == H_TOTAL + 3;
    end
    chk("reach_mid", 32'(hit), 1);
    #2 sys_rst = 1'b1;
    #1 check_all("arst_async");
    @(negedge sys_clk);
    check_all("arst_hold");
    sys_rst = 1'b0;
    repeat (FRAME_CYC + 20) begin
      @(negedge sys_clk);
      check_all("after_arst");
    end

    // enable dropped for 3 cycles during hsync.
    hit = 1'b0;
    for (int i = 0; i < 2 * LINE_CYC && !hit; i++) begin
      @(negedge sys_clk);
      check_all("seek_sync");
      e = model(k);
      hit = !e.hs;
    end
    chk("reach_sync", 32'(hit), 1);
    chk("in_sync", 32'(lcd_hsync), 0);
    enable = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      check_all("en_low");
      chk("en_low_hsync", 32'(lcd_hsync), 1);
    end
    enable = 1'b1;
    repeat (FRAME_CYC + 20) begin
      @(negedge sys_clk);
      check_all("after_en");
    end

    // Random enable drops and async reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      check_all("rand");
      r = int'($urandom_range(0, 999));
      enable = (r >= 3);
      if (r == 0) begin
        #2 sys_rst = 1'b1;
        #1 check_all("rand_arst");
        @(negedge sys_clk);
        check_all("rand_rst_hold");
        sys_rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
